// File: rtl/multiplicador_seq.sv
// multiplicador_seq: sequential shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH.
// It adds one partial product per clock through a single WIDTH+1-bit adder.
// Handshake is start/busy/done, and the product is held in s until the next product completes.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  request; accepted while busy==0 (IDLE or the one-cycle FIM state)
//   a, b   operands, captured when start is accepted
//   busy   high for the WIDTH calculation cycles
//   done   one-cycle pulse when s carries a new product
//   s      registered product
//
// Optional feature: define MULT_SIGNED_EN for two's-complement a, b and s.
// Without it the datapath is purely unsigned.

module multiplicador_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] s
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFim} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] s_q, s_d;

  logic [WIDTH-1:0]   op_a, op_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_next;
  logic [2*WIDTH-1:0] result;

`ifdef MULT_SIGNED_EN
  logic neg_q, neg_d;

  // Magnitudes: the most-negative value negates to itself, which read as unsigned is 2^(WIDTH-1).
  assign op_a   = a[WIDTH-1] ? -a : a;
  assign op_b   = b[WIDTH-1] ? -b : b;
  assign result = neg_q ? -prod_next : prod_next;
`else
  assign op_a   = a;
  assign op_b   = b;
  assign result = prod_next;
`endif

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    s_d     = s_q;
`ifdef MULT_SIGNED_EN
    neg_d   = neg_q;
`endif

    // Conditional add keeps the carry in bit WIDTH.
    // {sum, mq[WIDTH-1:1]} is then {acc,mq} shifted right by one.
    sum       = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : '0);
    prod_next = {sum, mq_q[WIDTH-1:1]};

    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (start) begin
          state_d = StCalc;
          busy_d  = 1'b1;
          mcand_d = op_a;
          mq_d    = op_b;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef MULT_SIGNED_EN
          neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
`endif
        end
      end
      StCalc: begin
        acc_d = prod_next[2*WIDTH-1:WIDTH];
        mq_d  = prod_next[WIDTH-1:0];
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFim;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          s_d     = result;
        end
      end
      StFim: begin
        // A start here is accepted without passing through IDLE.
        if (start) begin
          state_d = StCalc;
          busy_d  = 1'b1;
          mcand_d = op_a;
          mq_d    = op_b;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef MULT_SIGNED_EN
          neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
`endif
        end else begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mcand_q <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
`ifdef MULT_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      s_q     <= s_d;
`ifdef MULT_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;

endmodule
